// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// MemPortArbiter (module mem_port_arbiter)
//
// Shares one single-ported unified memory between the instruction-fetch port
// and the data (MEM stage) port. Accesses are serialised by a three-state FSM
// (IDLE / BUSY_IF / BUSY_DM), variable memory latency is absorbed through the
// mem_ready handshake, and per-port stall signals freeze the pipeline stage
// whose request is still outstanding. Data accesses win ties by default.
//
// Optional build macro: ARB_STARVE_GUARD_EN
//   When defined, a saturating counter tracks how many data grants were given
//   while fetch was also waiting; once it reaches STARVE_LIMIT, fetch wins the
//   next tie. When undefined the counter is not built and data always wins.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low (0 = in reset)
//   if_req     in   fetch request, held with if_addr until if_valid
//   if_addr    in   fetch address
//   if_rdata   out  fetched word (registered)
//   if_valid   out  one-cycle fetch completion pulse
//   dm_req     in   data request, held with payload until dm_valid
//   dm_we      in   1 = write, 0 = read
//   dm_addr    in   data address
//   dm_wdata   in   data write word
//   dm_rdata   out  data read word (registered, untouched by writes)
//   dm_valid   out  one-cycle data completion pulse
//   stall_if   out  if_req & ~if_valid (combinational)
//   stall_mem  out  dm_req & ~dm_valid (combinational)
//   mem_req    out  memory access in flight
//   mem_we     out  memory write enable
//   mem_addr   out  latched memory address
//   mem_wdata  out  latched memory write data
//   mem_rdata  in   memory read data, valid with mem_ready
//   mem_ready  in   access completes this cycle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY_IF = 2'b01,
      BUSY_DM = 2'b10
   } state_e;

   state_e            state_q,    state_d;
   logic              memReq_q,   memReq_d;
   logic              memWe_q,    memWe_d;
   logic [ADDR_W-1:0] memAddr_q,  memAddr_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [DATA_W-1:0] ifRdata_q,  ifRdata_d;
   logic              ifValid_q,  ifValid_d;
   logic [DATA_W-1:0] dmRdata_q,  dmRdata_d;
   logic              dmValid_q,  dmValid_d;

   logic ifElig;
   logic dmElig;
   logic forceIf;
   logic grantIf;
   logic grantDm;

   // A request raised (or still held) on its own completion cycle is the
   // tail of the access that just finished, so it must not be re-granted.
   assign ifElig = if_req & ~ifValid_q;
   assign dmElig = dm_req & ~dmValid_q;

   // Grants only happen from IDLE; data wins ties unless the guard says
   // fetch has waited long enough.
   assign grantIf = (state_q == IDLE) & ifElig & (~dmElig | forceIf);
   assign grantDm = (state_q == IDLE) & dmElig & ~grantIf;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

   assign forceIf = (starveCnt_q == CNT_W'(STARVE_LIMIT));

   // Counts data grants that overtook a waiting fetch; saturates because a
   // full counter forces the next tie to fetch, which clears it.
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (grantIf) begin
         starveCnt_d = '0;
      end else if (grantDm && ifElig && !forceIf) begin
         starveCnt_d = starveCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starveCnt_q <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end
`else
   assign forceIf = 1'b0;
`endif

   // Next-state and registered-output logic. The memory payload is captured
   // at grant time and then held so requester changes mid-access are ignored.
   always_comb begin
      state_d    = state_q;
      memReq_d   = memReq_q;
      memWe_d    = memWe_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      ifRdata_d  = ifRdata_q;
      dmRdata_d  = dmRdata_q;
      ifValid_d  = 1'b0;
      dmValid_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (grantIf) begin
               state_d   = BUSY_IF;
               memReq_d  = 1'b1;
               memWe_d   = 1'b0;
               memAddr_d = if_addr;
            end else if (grantDm) begin
               state_d    = BUSY_DM;
               memReq_d   = 1'b1;
               memWe_d    = dm_we;
               memAddr_d  = dm_addr;
               memWdata_d = dm_wdata;
            end
         end
         BUSY_IF: begin
            if (mem_ready) begin
               state_d   = IDLE;
               memReq_d  = 1'b0;
               ifValid_d = 1'b1;
               ifRdata_d = mem_rdata;
            end
         end
         BUSY_DM: begin
            if (mem_ready) begin
               state_d   = IDLE;
               memReq_d  = 1'b0;
               memWe_d   = 1'b0;
               dmValid_d = 1'b1;
               // Writes leave the last read value visible on dm_rdata.
               if (!memWe_q) begin
                  dmRdata_d = mem_rdata;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            memReq_d = 1'b0;
            memWe_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         ifRdata_q  <= '0;
         ifValid_q  <= 1'b0;
         dmRdata_q  <= '0;
         dmValid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         memReq_q   <= memReq_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         ifRdata_q  <= ifRdata_d;
         ifValid_q  <= ifValid_d;
         dmRdata_q  <= dmRdata_d;
         dmValid_q  <= dmValid_d;
      end
   end

   assign mem_req   = memReq_q;
   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign if_rdata  = ifRdata_q;
   assign if_valid  = ifValid_q;
   assign dm_rdata  = dmRdata_q;
   assign dm_valid  = dmValid_q;

   assign stall_if  = if_req & ~ifValid_q;
   assign stall_mem = dm_req & ~dmValid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mem_port_arbiter. A transaction-level reference model predicts
// each grant (port, payload) and each completion (port, data) from the
// arbitration rules and pushes them into queues; a separate monitor pops and
// compares whenever the DUT starts an access or pulses a valid.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int RAND_CYCLES  = 3000;

`ifdef ARB_STARVE_GUARD_EN
   localparam bit GuardOn = 1'b1;
`else
   localparam bit GuardOn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              stall_if;
   logic              stall_mem;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   mem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_valid (if_valid),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .dm_valid (dm_valid),
      .stall_if (stall_if),
      .stall_mem(stall_mem),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          isDm;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      bit          isDm;
      logic [31:0] data;
   } resp_t;

   grant_t grantQ[$];
   resp_t  respQ[$];

   int checks = 0;
   int errors = 0;
   bit draining = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner 0 = memory free, 1 = fetch, 2 = data.
   int          mOwner   = 0;
   bit          mIfPulse = 1'b0;
   bit          mDmPulse = 1'b0;
   bit          mCurWe   = 1'b0;
   int          mStarve  = 0;
   logic [31:0] mIfData  = '0;
   logic [31:0] mDmData  = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mOwner = 0; mIfPulse = 1'b0; mDmPulse = 1'b0; mCurWe = 1'b0;
         mStarve = 0; mIfData = '0; mDmData = '0;
         grantQ.delete();
         respQ.delete();
      end else begin
         bit ifDoneNow;
         bit dmDoneNow;
         bit eligIf;
         bit eligDm;
         bit pickIf;
         ifDoneNow = mIfPulse;
         dmDoneNow = mDmPulse;
         mIfPulse  = 1'b0;
         mDmPulse  = 1'b0;
         if (mOwner == 0) begin
            eligIf = if_req && !ifDoneNow;
            eligDm = dm_req && !dmDoneNow;
            pickIf = eligIf && (!eligDm || (GuardOn && mStarve == STARVE_LIMIT));
            if (pickIf) begin
               grantQ.push_back('{isDm: 1'b0, addr: if_addr, we: 1'b0, wdata: '0});
               mOwner  = 1;
               mStarve = 0;
            end else if (eligDm) begin
               grantQ.push_back('{isDm: 1'b1, addr: dm_addr, we: dm_we, wdata: dm_wdata});
               mOwner = 2;
               mCurWe = dm_we;
               if (eligIf && mStarve < STARVE_LIMIT) mStarve++;
            end
         end else if (mem_ready) begin
            if (mOwner == 1) begin
               mIfData  = mem_rdata;
               mIfPulse = 1'b1;
               respQ.push_back('{isDm: 1'b0, data: mIfData});
            end else begin
               if (!mCurWe) mDmData = mem_rdata;
               mDmPulse = 1'b1;
               respQ.push_back('{isDm: 1'b1, data: mDmData});
            end
            mOwner = 0;
         end
      end
   end

   // Monitor: samples just after the falling edge, away from the active edge.
   grant_t curGrant;
   bit     haveGrant  = 1'b0;
   bit     prevMemReq = 1'b0;

   always @(negedge clk) begin
      #1;
      if (!reset) begin
         prevMemReq = 1'b0;
         haveGrant  = 1'b0;
      end else begin
         checkOutput("stall_if", stall_if, if_req & ~if_valid);
         checkOutput("stall_mem", stall_mem, dm_req & ~dm_valid);
         if (mem_req && !prevMemReq) begin
            if (grantQ.size() == 0) begin
               checkOutput("unexpected grant", 1, 0);
               haveGrant = 1'b0;
            end else begin
               curGrant  = grantQ.pop_front();
               haveGrant = 1'b1;
            end
         end
         checkOutput("grant pending", grantQ.size(), 0);
         if (mem_req && haveGrant) begin
            checkOutput("mem_addr", mem_addr, curGrant.addr);
            checkOutput("mem_we", mem_we, curGrant.we);
            if (curGrant.we) checkOutput("mem_wdata", mem_wdata, curGrant.wdata);
         end
         if (if_valid || dm_valid) begin
            if (respQ.size() == 0) begin
               checkOutput("unexpected valid", 1, 0);
            end else begin
               resp_t r;
               r = respQ.pop_front();
               checkOutput("valid port", dm_valid, r.isDm);
               checkOutput("valid exclusive", if_valid & dm_valid, 0);
               if (r.isDm) checkOutput("dm_rdata", dm_rdata, r.data);
               else        checkOutput("if_rdata", if_rdata, r.data);
            end
         end
         checkOutput("response pending", respQ.size(), 0);
         checkOutput("if_rdata hold", if_rdata, mIfData);
         checkOutput("dm_rdata hold", dm_rdata, mDmData);
         prevMemReq = mem_req;
      end
   end

   // One cycle of random, protocol-respecting requester and memory behaviour.
   task automatic applyStimulus();
      if (if_req) begin
         if (if_valid) begin
            if (draining || $urandom_range(0, 3) == 0) if_req = 1'b0;
            else if_addr = $urandom;
         end
      end else if (!draining && $urandom_range(0, 2) == 0) begin
         if_req  = 1'b1;
         if_addr = $urandom;
      end
      if (dm_req) begin
         if (dm_valid) begin
            if (draining || $urandom_range(0, 3) == 0) begin
               dm_req = 1'b0;
            end else begin
               dm_we    = $urandom_range(0, 1) == 1;
               dm_addr  = $urandom;
               dm_wdata = $urandom;
            end
         end
      end else if (!draining && $urandom_range(0, 1) == 0) begin
         dm_req   = 1'b1;
         dm_we    = $urandom_range(0, 1) == 1;
         dm_addr  = $urandom;
         dm_wdata = $urandom;
      end
      mem_ready = draining || ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
   endtask

   initial begin
      logic [31:0] savedRdata;
      bit          drained;
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      checkOutput("reset mem_req", mem_req, 0);
      checkOutput("reset mem_we", mem_we, 0);
      checkOutput("reset if_valid", if_valid, 0);
      checkOutput("reset dm_valid", dm_valid, 0);
      checkOutput("reset mem_addr", mem_addr, 0);
      checkOutput("reset mem_wdata", mem_wdata, 0);
      checkOutput("reset if_rdata", if_rdata, 0);
      checkOutput("reset dm_rdata", dm_rdata, 0);
      reset = 1'b1;

      // Single fetch, then a fetch request held through its valid cycle.
      @(negedge clk); #2;
      if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk); #2;
      checkOutput("fetch cycle1 mem_req", mem_req, 1);
      checkOutput("fetch cycle1 mem_addr", mem_addr, 32'h10);
      @(negedge clk); #2;
      checkOutput("fetch cycle2 if_valid", if_valid, 1);
      checkOutput("fetch cycle2 if_rdata", if_rdata, 32'hDEADBEEF);
      checkOutput("fetch cycle2 stall_if", stall_if, 0);
      if_addr = 32'h14; mem_rdata = 32'h12345678;
      @(negedge clk); #2;
      checkOutput("held req no regrant", mem_req, 0);
      @(negedge clk); #2;
      checkOutput("second fetch mem_req", mem_req, 1);
      checkOutput("second fetch mem_addr", mem_addr, 32'h14);
      @(negedge clk); #2;
      checkOutput("second fetch if_valid", if_valid, 1);
      if_req = 1'b0;

      // Data write with three wait states.
      @(negedge clk); #2;
      savedRdata = dm_rdata;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h55; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #2;
         checkOutput("write mem_req held", mem_req, 1);
         checkOutput("write mem_we held", mem_we, 1);
         checkOutput("write mem_wdata held", mem_wdata, 32'h55);
         checkOutput("write no early valid", dm_valid, 0);
         if (i == 3) mem_ready = 1'b1;
      end
      @(negedge clk); #2;
      checkOutput("write dm_valid", dm_valid, 1);
      checkOutput("write dm_rdata unchanged", dm_rdata, savedRdata);
      dm_req = 1'b0;
      @(negedge clk); #2;
      checkOutput("write dm_valid single pulse", dm_valid, 0);

      // Randomised traffic.
      for (int c = 0; c < RAND_CYCLES; c++) begin
         @(negedge clk); #2;
         applyStimulus();
      end

      // Let outstanding requests complete, bounded.
      draining = 1'b1;
      drained  = 1'b0;
      for (int c = 0; c < 300 && !drained; c++) begin
         @(negedge clk); #2;
         applyStimulus();
         drained = !if_req && !dm_req && !mem_req;
      end
      checkOutput("drain completed", drained, 1);

      // Reset in the middle of a data read.
      @(negedge clk); #2;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hABC; mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk); #2;
      checkOutput("busy before reset", mem_req, 1);
      reset = 1'b0;
      #1;
      checkOutput("mem_req async drop", mem_req, 0);
      checkOutput("no dm_valid on reset", dm_valid, 0);
      dm_req = 1'b0; mem_ready = 1'b1;
      @(negedge clk); #2;
      checkOutput("dm_rdata after reset", dm_rdata, 0);
      reset = 1'b1;
      @(negedge clk); #2;
      checkOutput("idle after reset", mem_req, 0);
      checkOutput("no late dm_valid", dm_valid, 0);

      // A fresh fetch after reset goes through normally.
      if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'hCAFE0001;
      @(negedge clk); #2;
      checkOutput("post-reset fetch grant", mem_req, 1);
      @(negedge clk); #2;
      checkOutput("post-reset fetch valid", if_valid, 1);
      if_req = 1'b0;
      repeat (2) @(negedge clk);
      #2;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
